// File: rtl/decode_stage.sv
// Pipelined instruction decode stage with a one-entry skid buffer.
// Ports: clk/rst, in_valid/in_ready/in_instr, flush, out_valid/out_ready,
//   decoded fields (opcode, reg1..3, isaluop, aluop, bigval, smallval, imm),
//   count of completed output handshakes.
module decode_stage #(
    parameter int NIB_SIZE    = 4,
    parameter int WORD_SIZE   = 16,
    parameter int SEXT        = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_SIZE-1:0]   in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_SIZE-1:0]    opcode,
    output logic [NIB_SIZE-1:0]    reg1,
    output logic [NIB_SIZE-1:0]    reg2,
    output logic [NIB_SIZE-1:0]    reg3,
    output logic                   isaluop,
    output logic [NIB_SIZE-2:0]    aluop,
    output logic [2*NIB_SIZE-1:0]  bigval,
    output logic [NIB_SIZE-1:0]    smallval,
    output logic [WORD_SIZE-1:0]   imm,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int BW = 2 * NIB_SIZE;

    if (WORD_SIZE != 4 * NIB_SIZE) begin : g_bad_size
        $error("decode_stage: WORD_SIZE must equal 4*NIB_SIZE");
    end

    typedef struct packed {
        logic [NIB_SIZE-1:0]  opcode;
        logic [NIB_SIZE-1:0]  reg1;
        logic [NIB_SIZE-1:0]  reg2;
        logic [NIB_SIZE-1:0]  reg3;
        logic                 isaluop;
        logic [NIB_SIZE-2:0]  aluop;
        logic [BW-1:0]        bigval;
        logic [NIB_SIZE-1:0]  smallval;
        logic [WORD_SIZE-1:0] imm;
    } dec_t;

    dec_t                   dec;
    dec_t                   or_data_q, or_data_d;
    dec_t                   sr_data_q, sr_data_d;
    logic                   or_valid_q, or_valid_d;
    logic                   sr_valid_q, sr_valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   accept;
    logic                   drain;
    logic                   ext_bit;

    // Decode happens on the way in so both storage slots hold ready fields.
    always_comb begin
        dec          = '0;
        dec.opcode   = in_instr[WORD_SIZE-1 -: NIB_SIZE];
        dec.reg1     = in_instr[3*NIB_SIZE-1 -: NIB_SIZE];
        dec.reg2     = in_instr[2*NIB_SIZE-1 -: NIB_SIZE];
        dec.reg3     = in_instr[NIB_SIZE-1:0];
        dec.isaluop  = ~in_instr[WORD_SIZE-1];
        dec.aluop    = dec.opcode[NIB_SIZE-2:0];
        dec.bigval   = in_instr[BW-1:0];
        dec.smallval = in_instr[NIB_SIZE-1:0];
        ext_bit      = (SEXT != 0) & in_instr[BW-1];
        dec.imm      = {{(WORD_SIZE-BW){ext_bit}}, in_instr[BW-1:0]};
    end

    // Ready comes from registered state only, so no path from out_ready.
    assign in_ready = ~sr_valid_q & ~rst;
    assign accept   = in_valid & in_ready;
    assign drain    = or_valid_q & out_ready;

    always_comb begin
        or_data_d  = or_data_q;
        sr_data_d  = sr_data_q;
        or_valid_d = or_valid_q;
        sr_valid_d = sr_valid_q;
        count_d    = count_q + {{(COUNT_WIDTH-1){1'b0}}, drain};
        if (flush) begin
            // Data registers keep their contents; only validity is dropped.
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (!or_valid_q || drain) begin
            if (sr_valid_q) begin
                or_data_d  = sr_data_q;
                or_valid_d = 1'b1;
                sr_valid_d = 1'b0;
            end else if (accept) begin
                or_data_d  = dec;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sr_data_d  = dec;
            sr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_data_q  <= '0;
            sr_data_q  <= '0;
            or_valid_q <= 1'b0;
            sr_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            or_data_q  <= or_data_d;
            sr_data_q  <= sr_data_d;
            or_valid_q <= or_valid_d;
            sr_valid_q <= sr_valid_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = or_valid_q;
    assign opcode    = or_data_q.opcode;
    assign reg1      = or_data_q.reg1;
    assign reg2      = or_data_q.reg2;
    assign reg3      = or_data_q.reg3;
    assign isaluop   = or_data_q.isaluop;
    assign aluop     = or_data_q.aluop;
    assign bigval    = or_data_q.bigval;
    assign smallval  = or_data_q.smallval;
    assign imm       = or_data_q.imm;
    assign count     = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  opcode, reg1, reg2, reg3, smallval;
    logic        isaluop;
    logic [2:0]  aluop;
    logic [7:0]  bigval;
    logic [15:0] imm;
    logic [15:0] count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [15:0] in_instr2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [3:0]  opcode2, reg1_2, reg2_2, reg3_2, smallval2;
    logic        isaluop2;
    logic [2:0]  aluop2;
    logic [7:0]  bigval2;
    logic [15:0] imm2;
    logic [3:0]  count2;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .reg1(reg1), .reg2(reg2),
        .reg3(reg3), .isaluop(isaluop), .aluop(aluop), .bigval(bigval),
        .smallval(smallval), .imm(imm), .count(count)
    );

    decode_stage #(.SEXT(0), .COUNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .flush(1'b0), .out_valid(out_valid2),
        .out_ready(out_ready2), .opcode(opcode2), .reg1(reg1_2),
        .reg2(reg2_2), .reg3(reg3_2), .isaluop(isaluop2), .aluop(aluop2),
        .bigval(bigval2), .smallval(smallval2), .imm(imm2), .count(count2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: held instructions in FIFO order (at most two).
    logic [15:0] q[$];
    logic [15:0] last_word = '0;
    bit          have_word = 1'b0;
    int unsigned exp_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit drn;
        bit acc;
        @(posedge clk);
        drn = (q.size() > 0) && out_ready;
        acc = in_valid && (q.size() < 2);
        if (drn) begin
            void'(q.pop_front());
            exp_count = (exp_count + 1) % 65536;
        end
        if (flush) q.delete();
        else if (acc) q.push_back(in_instr);
        if (q.size() > 0) begin
            last_word = q[0];
            have_word = 1'b1;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        int unsigned w, op, bv, ex;
        w  = have_word ? int'(last_word) : 0;
        op = w / 4096;
        bv = w % 256;
        ex = (bv >= 128) ? bv + 16'hFF00 : bv;
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        chk({tag, ".in_ready"}, in_ready, q.size() < 2);
        chk({tag, ".count"}, count, exp_count);
        chk({tag, ".word"}, {opcode, reg1, reg2, reg3}, w);
        chk({tag, ".isaluop"}, isaluop, have_word ? (op < 8) : 0);
        chk({tag, ".aluop"}, aluop, op % 8);
        chk({tag, ".bigval"}, bigval, bv);
        chk({tag, ".smallval"}, smallval, w % 16);
        chk({tag, ".imm"}, imm, have_word ? ex : 0);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.count", count, 0);
        chk("rst.isaluop", isaluop, 0);
        chk("rst.imm", imm, 0);
        rst = 1'b0;
        #1;
        chk("rel.in_ready", in_ready, 1);

        // Basic decode
        in_valid  = 1'b1;
        in_instr  = 16'h3A5F;
        out_ready = 1'b1;
        tick();
        chk("d1.out_valid", out_valid, 1);
        chk("d1.opcode", opcode, 4'h3);
        chk("d1.isaluop", isaluop, 1);
        chk("d1.aluop", aluop, 3);
        chk("d1.regs", {reg1, reg2, reg3}, 12'hA5F);
        chk("d1.bigval", bigval, 8'h5F);
        chk("d1.smallval", smallval, 4'hF);
        chk("d1.imm", imm, 16'h005F);
        check_model("d1");

        in_instr   = 16'h81C4;
        in_valid2  = 1'b1;
        in_instr2  = 16'h81C4;
        out_ready2 = 1'b1;
        tick();
        chk("d2.isaluop", isaluop, 0);
        chk("d2.aluop", aluop, 0);
        chk("d2.bigval", bigval, 8'hC4);
        chk("d2.imm", imm, 16'hFFC4);
        chk("d2.zext_imm", imm2, 16'h00C4);
        chk("d2.zext_valid", out_valid2, 1);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        tick();
        chk("d2.count", count, 2);
        check_model("d2");

        // Back-pressure: fill output and skid slots
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h1000;
        tick();
        in_instr = 16'h1001;
        tick();
        in_instr = 16'h1002;
        tick();
        chk("bp.in_ready", in_ready, 0);
        chk("bp.head", {opcode, reg1, reg2, reg3}, 16'h1000);
        check_model("bp0");
        out_ready = 1'b1;
        tick();
        chk("bp.o1", {opcode, reg1, reg2, reg3}, 16'h1001);
        tick();
        chk("bp.o2", {opcode, reg1, reg2, reg3}, 16'h1002);
        in_valid = 1'b0;
        tick();
        chk("bp.count", count, 5);
        check_model("bp1");

        // Flush with both slots full and an offer in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'hA001;
        tick();
        in_instr = 16'hA002;
        tick();
        in_instr = 16'hA003;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.out_valid", out_valid, 0);
        chk("fl.in_ready", in_ready, 1);
        chk("fl.count", count, 5);
        check_model("fl0");
        in_valid  = 1'b1;
        in_instr  = 16'h2222;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fl.new", {opcode, reg1, reg2, reg3}, 16'h2222);
        chk("fl.new_valid", out_valid, 1);
        tick();
        chk("fl.new_gone", out_valid, 0);
        check_model("fl1");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 16) == 0;
            in_instr  = 16'($urandom);
            tick();
            check_model("rnd");
        end
        flush = 1'b0;

        // Asynchronous reset between edges with output valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h5555;
        tick();
        in_valid = 1'b0;
        chk("ar.pre_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar.out_valid", out_valid, 0);
        chk("ar.count", count, 0);
        chk("ar.in_ready", in_ready, 0);
        chk("ar.count2", count2, 0);
        q.delete();
        exp_count = 0;
        have_word = 1'b0;
        last_word = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ar.rel_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check_model("ar1");
        tick();
        check_model("ar2");

        // Counter wrap on the 4-bit instance: 17 drains
        in_valid2  = 1'b1;
        in_instr2  = 16'h0F0F;
        out_ready2 = 1'b1;
        repeat (17) tick();
        in_valid2 = 1'b0;
        repeat (3) tick();
        chk("wrap.count2", count2, 1);
        chk("wrap.valid2", out_valid2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined successor to the combinational instruction decoder.
- Sits between fetch and execute. Accepts raw instruction words over a valid/ready handshake and presents registered decoded fields with a 1-cycle latency.
- Contains a one-entry skid buffer so full throughput is sustained under back-pressure.
- Adds pipeline flush, immediate extension and a retired-decode counter. Field widths are parametrised.

Parameters:
- NIB_SIZE, 4, width of each instruction field (opcode, reg1, reg2, reg3).
- WORD_SIZE, 16, instruction width; must equal 4*NIB_SIZE (elaboration error otherwise).
- SEXT, 1, 1 = sign-extend bigval into imm; 0 = zero-extend.
- COUNT_WIDTH, 16, width of the decode counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_instr holds a valid instruction
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  WORD_SIZE  raw instruction {opcode, reg1, reg2, reg3}, opcode in MSBs
- flush  input  1  discard all held instructions
- out_valid  output  1  decoded outputs are valid
- out_ready  input  1  consumer accepts the decoded outputs
- opcode, reg1, reg2, reg3  output  NIB_SIZE each  instruction fields
- isaluop  output  1  inverse of the opcode MSB
- aluop  output  NIB_SIZE-1  opcode without its MSB
- bigval  output  2*NIB_SIZE  {reg2, reg3}
- smallval  output  NIB_SIZE  equal to reg3
- imm  output  WORD_SIZE  bigval extended per SEXT
- count  output  COUNT_WIDTH  number of completed output handshakes

Behaviour:
- Reset (async, immediate): out_valid=0, skid empty, count=0, all decoded outputs 0. in_ready=0 while rst is high; it is 1 on the first cycle after release.
- Storage: output register (OR) and skid register (SR). Each holds a decoded field set plus a valid bit. Decoding is done on capture.
- in_ready = !SR.valid && !rst. It depends only on registered state; there is no combinational path from out_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Each clock edge, with flush=0:
  - Case 1: OR empty, or draining. If SR is valid, SR moves to OR; otherwise an accepted instruction loads OR directly.
  - Case 2: OR valid and not draining. An accepted instruction loads SR.
  - Case 3: SR valid and OR draining. SR moves to OR and SR empties. No accept can occur because in_ready=0.
- Latency: accept at edge N means outputs are valid after edge N when the stage was empty. Throughput is 1 instruction per cycle while out_ready=1.
- Ordering is strictly FIFO; no instruction is duplicated or dropped unless flushed.
- Decoded outputs hold their last value when out_valid=0. They change only when OR loads.
- flush=1 at an edge:
  - OR.valid and SR.valid are cleared; an accept in the same cycle is discarded.
  - A drain in that cycle still counts, because the consumer sampled it.
  - Decoded data registers are unchanged.
- count increments by 1 on each drain and wraps from all-ones to 0.
- imm: SEXT=1 replicates bigval[2*NIB_SIZE-1] into the upper bits; SEXT=0 fills them with zeros.
- Reset mid-operation discards all contents immediately. Nothing is emitted after release until a new accept.

Test Plan:
- Decode, SEXT=1: 3A5F, out_ready=1 -> next cycle out_valid=1, opcode=3, isaluop=1, aluop=3, reg1=A, reg2=5, reg3=F, bigval=5F, smallval=F, imm=005F.
- Decode, non-ALU op: 81C4 -> isaluop=0, aluop=0, bigval=C4, imm=FFC4. Same instruction with SEXT=0 -> imm=00C4.
- Back-pressure: stream 1000,1001,1002 with out_ready=0 -> OR=1000, SR=1001, in_ready=0, 1002 held by the source. Raise out_ready -> outputs 1000,1001,1002 on consecutive cycles, count=3.
- Flush with OR and SR full, plus in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, count unchanged. The next accepted word 2222 appears with nothing stale ahead of it.
- Counter wrap: COUNT_WIDTH=4, 17 drains -> count=1.
- Async reset asserted between edges while OR is valid -> out_valid=0, count=0 and in_ready=0 immediately. After release, in_ready=1 and there is no output until a new accept.
